// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared types and constants for the fetch stage
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_VALID = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_e;

  localparam int WORD_BYTES = 4;
  localparam int IMM16_W    = 16;
  localparam int IMM26_W    = 26;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_npc_calc.sv
// rtl/fetch_unit_npc_calc.sv - combinational next-PC selection for the fetch stage
module fetch_unit_npc_calc
  import fetch_unit_pkg::*;
(
  input  logic [31:0]        pc,
  input  logic [IMM26_W-1:0] instr_imm,
  input  logic               branch,
  input  logic               branch_ne,
  input  logic               zero,
  input  logic               jump,
  input  logic               jump_reg,
  input  logic [31:0]        reg_target,
  output logic [31:0]        npc,
  output logic [31:0]        pc_plus4
);

  logic [31:0] imm16_ext;
  logic [31:0] imm26_ext;
  logic        taken;
  logic [31:0] raw_npc;

  assign pc_plus4  = pc + 32'(WORD_BYTES);
  assign imm16_ext = {{(32-IMM16_W){instr_imm[IMM16_W-1]}}, instr_imm[IMM16_W-1:0]};
  assign imm26_ext = {{(32-IMM26_W){instr_imm[IMM26_W-1]}}, instr_imm};
  assign taken     = branch & (branch_ne ? ~zero : zero);

  always_comb begin
    raw_npc = pc_plus4;
    if (jump_reg) begin
      raw_npc = reg_target;
    end else if (jump) begin
      raw_npc = pc_plus4 + imm26_ext;
    end else if (taken) begin
      raw_npc = pc_plus4 + imm16_ext;
    end
  end

  // Targets are always word aligned; stray low bits are simply discarded.
  assign npc = raw_npc & ~32'd3;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, imem handshake, instruction register
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic [31:0] instruction,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        branch,
  input  logic        branch_ne,
  input  logic        zero,
  input  logic        jump,
  input  logic        jump_reg,
  input  logic [31:0] reg_target,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        fetch_fault
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic         valid_q, valid_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [31:0]  npc;

  fetch_unit_npc_calc u_npc_calc (
    .pc         (pc_q),
    .instr_imm  (instr_q[IMM26_W-1:0]),
    .branch     (branch),
    .branch_ne  (branch_ne),
    .zero       (zero),
    .jump       (jump),
    .jump_reg   (jump_reg),
    .reg_target (reg_target),
    .npc        (npc),
    .pc_plus4   (pc_plus4)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      valid_q <= 1'b0;
      cnt_q   <= 8'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    case (state_q)
      // One dead cycle after reset so a late ack from an aborted fetch is dropped.
      ST_IDLE: begin
        state_d = ST_FETCH;
        cnt_d   = 8'h0;
      end
      ST_FETCH: begin
        if (imem_ack) begin
          instr_d = imem_data;
          valid_d = 1'b1;
          cnt_d   = 8'h0;
          state_d = ST_VALID;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          cnt_d   = 8'h0;
          state_d = ST_FAULT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_VALID: begin
        if (instr_ready) begin
          pc_d    = npc;
          valid_d = 1'b0;
          state_d = ST_FETCH;
        end
      end
      ST_FAULT: begin
        valid_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign imem_req    = (state_q == ST_FETCH);
  assign imem_addr   = pc_q;
  assign pc_out      = pc_q;
  assign instruction = instr_q;
  assign instr_valid = valid_q;
  assign fetch_fault = (state_q == ST_FAULT);

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with a behavioural next-PC model
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          TMO    = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_data = 32'h0;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        branch = 1'b0;
  logic        branch_ne = 1'b0;
  logic        zero = 1'b0;
  logic        jump = 1'b0;
  logic        jump_reg = 1'b0;
  logic [31:0] reg_target = 32'h0;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        fetch_fault;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_instr_q[$];
  logic [31:0] exp_ipc_q[$];
  logic [31:0] model_pc;

  fetch_unit #(.RESET_PC(RST_PC), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data),
    .instruction(instruction), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .branch(branch), .branch_ne(branch_ne), .zero(zero),
    .jump(jump), .jump_reg(jump_reg), .reg_target(reg_target),
    .pc_out(pc_out), .pc_plus4(pc_plus4), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference next-PC: priority JR > J > taken branch > sequential, word aligned.
  function automatic logic [31:0] model_npc(input logic [31:0] pc, input logic [31:0] ins,
                                            input logic br, input logic bne, input logic z,
                                            input logic j, input logic jr, input logic [31:0] tgt);
    logic [31:0]        seq;
    logic [31:0]        r;
    logic signed [25:0] off26;
    logic signed [15:0] off16;
    seq   = pc + 32'd4;
    off26 = ins[25:0];
    off16 = ins[15:0];
    if (jr)                 r = tgt;
    else if (j)             r = seq + 32'(off26);
    else if (br && (z ^ bne)) r = seq + 32'(off16);
    else                    r = seq;
    return {r[31:2], 2'b00};
  endfunction

  // Monitor: pops expectations when the DUT presents a new request or a new instruction.
  logic        prev_req = 1'b0;
  logic        prev_vld = 1'b0;
  logic [31:0] hold_instr = 32'h0;
  logic [31:0] hold_pc = 32'h0;
  logic [31:0] e;

  always @(negedge clk) begin
    if (rst) begin
      prev_req = 1'b0;
      prev_vld = 1'b0;
    end else begin
      if (imem_req && !prev_req) begin
        check("req_expected", 32'(exp_addr_q.size() != 0), 32'd1);
        if (exp_addr_q.size() != 0) begin
          e = exp_addr_q.pop_front();
          check("imem_addr", imem_addr, e);
          check("pc_plus4", pc_plus4, e + 32'd4);
        end
      end
      if (instr_valid && !prev_vld) begin
        check("instr_expected", 32'(exp_instr_q.size() != 0), 32'd1);
        if (exp_instr_q.size() != 0) begin
          hold_instr = exp_instr_q.pop_front();
          hold_pc    = exp_ipc_q.pop_front();
        end
      end
      if (instr_valid) begin
        check("instruction", instruction, hold_instr);
        check("pc_out", pc_out, hold_pc);
      end
      prev_req = imem_req;
      prev_vld = instr_valid;
    end
  end

  task automatic wait_req(output int waited);
    waited = 0;
    while (!imem_req && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!imem_req) check("req_wait_bound", 32'(imem_req), 32'd1);
  endtask

  task automatic fetch_one(input logic [31:0] data, input int ack_dly, input int rdy_dly,
                           input logic spurious, input logic br, input logic bne, input logic z,
                           input logic j, input logic jr, input logic [31:0] tgt,
                           output int waited);
    logic [31:0] n;
    wait_req(waited);
    for (int i = 0; i < ack_dly; i++) @(negedge clk);
    imem_ack  = 1'b1;
    imem_data = data;
    exp_instr_q.push_back(data);
    exp_ipc_q.push_back(model_pc);
    @(negedge clk);
    imem_ack  = 1'b0;
    imem_data = $urandom;
    for (int i = 0; i < rdy_dly; i++) begin
      if (spurious) begin
        imem_ack  = 1'($urandom_range(0, 1));
        imem_data = $urandom;
      end
      @(negedge clk);
      check("valid_req_low", 32'(imem_req), 32'd0);
    end
    imem_ack    = 1'b0;
    instr_ready = 1'b1;
    branch      = br;
    branch_ne   = bne;
    zero        = z;
    jump        = j;
    jump_reg    = jr;
    reg_target  = tgt;
    n = model_npc(model_pc, data, br, bne, z, j, jr, tgt);
    model_pc = n;
    exp_addr_q.push_back(n);
    @(negedge clk);
    instr_ready = 1'b0;
    branch      = 1'($urandom_range(0, 1));
    jump        = 1'($urandom_range(0, 1));
    jump_reg    = 1'($urandom_range(0, 1));
    reg_target  = $urandom;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_ack = 1'b0;
    exp_addr_q.delete();
    exp_instr_q.delete();
    exp_ipc_q.delete();
    model_pc = RST_PC;
    exp_addr_q.push_back(RST_PC);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int w;
    int n;
    int guard;
    model_pc = RST_PC;
    @(negedge clk);
    @(negedge clk);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_fault", 32'(fetch_fault), 32'd0);
    check("rst_pc", pc_out, RST_PC);
    check("rst_instr", instruction, 32'h0);
    do_reset();

    // Sequential fetches at full rate
    fetch_one(32'h11, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, w);
    fetch_one(32'h22, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, w);
    check("throughput", 32'(w), 32'd0);
    fetch_one(32'h33, 0, 0, 0, 0, 0, 0, 0, 1, 32'h8, w);
    check("throughput", 32'(w), 32'd0);
    // BEQZ taken / not taken, BNEZ taken, all from pc 0x8
    fetch_one(32'h0000_0010, 0, 0, 0, 1, 0, 1, 0, 0, 32'h0, w);
    fetch_one(32'h0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h8, w);
    fetch_one(32'h0000_0010, 0, 0, 0, 1, 0, 0, 0, 0, 32'h0, w);
    fetch_one(32'h0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h8, w);
    fetch_one(32'h0000_0010, 0, 0, 0, 1, 1, 0, 0, 0, 32'h0, w);
    // Backward jump and JR-over-J priority
    fetch_one(32'h0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h20, w);
    fetch_one(32'h03FF_FFFC, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0, w);
    fetch_one(32'h0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h40, w);
    fetch_one(32'h0000_0008, 0, 0, 0, 0, 0, 0, 1, 1, 32'h103, w);
    // Backpressure with spurious acks, then wrap from the top of memory
    fetch_one(32'hDEAD_BEEF, 1, 5, 1, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, w);
    fetch_one(32'h1234_5678, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, w);

    for (int k = 0; k < 40; k++) begin
      fetch_one($urandom, $urandom_range(0, 5), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0), $urandom, w);
    end

    // Reset in the middle of a fetch, with a stale ack landing in IDLE
    wait_req(w);
    @(negedge clk);
    rst = 1'b1;
    exp_addr_q.delete();
    exp_instr_q.delete();
    exp_ipc_q.delete();
    model_pc = RST_PC;
    exp_addr_q.push_back(RST_PC);
    @(negedge clk);
    rst       = 1'b0;
    imem_ack  = 1'b1;
    imem_data = 32'hBAD0_BAD0;
    @(negedge clk);
    imem_ack = 1'b0;
    check("stale_ack_valid", 32'(instr_valid), 32'd0);
    check("post_rst_req", 32'(imem_req), 32'd1);
    fetch_one(32'h55, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, w);

    // Timeout to FAULT, then recovery by reset
    wait_req(w);
    do_reset();
    n = 0;
    guard = 0;
    while (!fetch_fault && guard < 60) begin
      @(negedge clk);
      guard++;
      if (imem_req) n++;
    end
    check("timeout_cycles", 32'(n), 32'(TMO));
    check("fault_req", 32'(imem_req), 32'd0);
    imem_ack = 1'b1;
    repeat (5) @(negedge clk);
    imem_ack = 1'b0;
    check("fault_sticky", 32'(fetch_fault), 32'd1);
    check("fault_valid", 32'(instr_valid), 32'd0);
    check("fault_req_held", 32'(imem_req), 32'd0);
    do_reset();
    check("fault_cleared", 32'(fetch_fault), 32'd0);
    fetch_one(32'h66, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, w);
    fetch_one(32'h77, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, w);

    repeat (3) @(negedge clk);
    check("addr_q_drained", 32'(exp_addr_q.size()), 32'd0);
    check("instr_q_drained", 32'(exp_instr_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
